// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state type and frame bit counts.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned DATA_BITS_7 = 7;
  localparam int unsigned DATA_BITS_8 = 8;
  localparam int unsigned STOP_BITS_1 = 1;
  localparam int unsigned STOP_BITS_2 = 2;

  function automatic logic parity_en(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a registered falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic sync1, sync2, sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= rx_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rx_sync = sync2;
  assign rx_fall = sync_d & ~sync2;

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver (7/8 data bits, optional parity, 1/2 stop bits).
// Define UART_RX_PARITY_CHECK_EN to report parity mismatches on parity_error.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_os,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       framing_error
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    data_q;
  logic          len8_q, two_stop_q, par_en_q, frame_err_q;
  logic          rx_bit, rx_fall;
  logic          mid_tick, last_data, last_stop;
  logic          start_det, glitch, frame_end;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .rx_sync (rx_bit),
    .rx_fall (rx_fall)
  );

  assign mid_tick  = tick_os && (tick_cnt == MID);
  assign last_data = bit_cnt == (len8_q ? 3'(DATA_BITS_8 - 1) : 3'(DATA_BITS_7 - 1));
  assign last_stop = bit_cnt == (two_stop_q ? 3'(STOP_BITS_2 - 1) : 3'(STOP_BITS_1 - 1));
  assign start_det = (state == IDLE) && rx_fall;
  assign glitch    = (state == START) && mid_tick && rx_bit;
  assign frame_end = (state == STOP) && mid_tick && last_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (rx_fall) state_n = START;
      START:     if (mid_tick) state_n = rx_bit ? IDLE : DATA;
      DATA:      if (mid_tick && last_data) state_n = par_en_q ? PARITY : STOP;
      PARITY:    if (mid_tick) state_n = STOP;
      STOP:      if (mid_tick && last_stop) state_n = rx_bit ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_bit) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // The tick counter free-runs through the frame so every later sample lands on a bit midpoint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      data_q        <= '0;
      len8_q        <= 1'b0;
      two_stop_q    <= 1'b0;
      par_en_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      data_out      <= '0;
      rx_done       <= 1'b0;
      rx_active     <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_done <= frame_end;
      if (start_det)    tick_cnt <= '0;
      else if (tick_os) tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;

      if (state_n != state) bit_cnt <= '0;
      else if (mid_tick && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 3'd1;

      if (start_det) begin
        rx_active   <= 1'b1;
        len8_q      <= data_length;
        two_stop_q  <= stop_bits;
        par_en_q    <= parity_en(parity_type);
        data_q      <= '0;
        frame_err_q <= 1'b0;
      end
      if (glitch) rx_active <= 1'b0;
      if (state == DATA && mid_tick) data_q[bit_cnt] <= rx_bit;
      if (state == STOP && mid_tick && !rx_bit) frame_err_q <= 1'b1;
      if (frame_end) begin
        rx_active     <= 1'b0;
        data_out      <= data_q;
        framing_error <= frame_err_q | ~rx_bit;
      end
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic par_odd_q, par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_odd_q    <= 1'b0;
      par_err_q    <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (start_det) begin
        par_odd_q <= (parity_type == PAR_ODD);
        par_err_q <= 1'b0;
      end
      if (state == PARITY && mid_tick) par_err_q <= ((^data_q) ^ rx_bit) != par_odd_q;
      if (frame_end) parity_error <= par_err_q;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_sipo;

  logic       clk = 1'b0, rst = 1'b1, tick_os = 1'b0, rx_in = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0, data_length = 1'b1;
  logic [7:0] data_out;
  logic       rx_done, rx_active, parity_error, framing_error;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  frm_t       exp_q[$];
  frm_t       got;
  logic [7:0] hold_d = 8'h00;
  logic       hold_pe = 1'b0, hold_fe = 1'b0;
  int         nchk = 0, nerr = 0, tcnt = 0, act_cyc = 0;
  logic [7:0] r_d;
  logic [1:0] r_pt, r_stops;
  logic       r_st, r_dl, r_pbit;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam logic PE_CHECKED = 1'b1;
`else
  localparam logic PE_CHECKED = 1'b0;
`endif

  uart_rx_sipo #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_os       (tick_os),
    .rx_in         (rx_in),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .data_length   (data_length),
    .data_out      (data_out),
    .rx_done       (rx_done),
    .rx_active     (rx_active),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks: a bit period is 16 ticks = 64 clocks.
  initial forever begin
    @(negedge clk);
    tick_os = (tcnt == 3);
    tcnt    = (tcnt + 1) % 4;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic par_bit(input logic [7:0] dm, input logic odd);
    return odd ? ~(^dm) : (^dm);
  endfunction

  function automatic frm_t model(input logic [7:0] d, input logic [1:0] pt, input logic dl,
                                 input logic pbit, input logic [1:0] stops, input logic st);
    frm_t f;
    int   ones;
    f.d  = dl ? d : (d & 8'h7F);
    ones = $countones(f.d) + int'(pbit);
    f.pe = PE_CHECKED && (pt == 2'b01 || pt == 2'b10) && ((ones % 2 == 1) != (pt == 2'b01));
    f.fe = !stops[0] || (st && !stops[1]);
    return f;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick_os !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    wait_ticks(n);
  endtask

  // Leaves the line at the last stop-bit level after holding it a full bit period.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic st, input logic dl,
                            input logic pbit, input logic [1:0] stops, input logic scramble);
    exp_q.push_back(model(d, pt, dl, pbit, stops, st));
    parity_type = pt;
    stop_bits   = st;
    data_length = dl;
    rx_in = 1'b0;
    wait_ticks(2);
    if (scramble) {parity_type, stop_bits, data_length} = 4'($urandom);
    chk("active_in_frame", rx_active, 1);
    wait_ticks(14);
    for (int i = 0; i < (dl ? 8 : 7); i++) begin
      rx_in = d[i];
      wait_ticks(16);
    end
    if (pt == 2'b01 || pt == 2'b10) begin
      rx_in = pbit;
      wait_ticks(16);
    end
    rx_in = stops[0];
    wait_ticks(16);
    if (st) begin
      rx_in = stops[1];
      wait_ticks(16);
    end
    chk("active_after_frame", rx_active, 0);
  endtask

  always @(negedge clk) begin
    if (rx_active === 1'b1) act_cyc++;
    if (rst) begin
      hold_d  = 8'h00;
      hold_pe = 1'b0;
      hold_fe = 1'b0;
      chk("rst_done", rx_done, 0);
      chk("rst_data", data_out, 0);
    end else if (rx_done !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rx_done", rx_done, 0);
      end else begin
        got = exp_q.pop_front();
        chk("frame_data", data_out, got.d);
        chk("frame_parity_error", parity_error, got.pe);
        chk("frame_framing_error", framing_error, got.fe);
        hold_d  = got.d;
        hold_pe = got.pe;
        hold_fe = got.fe;
      end
    end else begin
      chk("hold_data", data_out, hold_d);
      chk("hold_parity_error", parity_error, hold_pe);
      chk("hold_framing_error", framing_error, hold_fe);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", data_out, 8'h00);
    chk("reset_done", rx_done, 0);
    chk("reset_active", rx_active, 0);
    chk("reset_pe", parity_error, 0);
    chk("reset_fe", framing_error, 0);
    @(negedge clk) rst = 1'b0;
    wait_ticks(20);

    // 8N1 0xA5
    act_cyc = 0;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    chk("8n1_data", data_out, 8'hA5);
    chk("8n1_pe", parity_error, 0);
    chk("8n1_fe", framing_error, 0);
    chk("8n1_active_len", (act_cyc >= 9 * 64 && act_cyc <= 10 * 64), 1);
    idle(32);

    // 7E2 0x41, good then bad parity bit
    send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
    chk("7e2_data", data_out, 8'h41);
    chk("7e2_pe_good", parity_error, 0);
    idle(32);
    send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    chk("7e2_data_bad", data_out, 8'h41);
    chk("7e2_pe_bad", parity_error, 32'(PE_CHECKED));
    idle(32);

    // Low glitch of 4 ticks
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(6);
    chk("glitch_active", rx_active, 0);
    wait_ticks(40);

    // 8O1 0x3C with low stop, then a 20-bit break, then 0x11
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    chk("break_data", data_out, 8'h3C);
    chk("break_fe", framing_error, 1);
    wait_ticks(20 * 16);
    chk("break_active", rx_active, 0);
    idle(16);
    send_frame(8'h11, 2'b01, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
    chk("after_break_data", data_out, 8'h11);
    chk("after_break_fe", framing_error, 0);
    idle(32);

    // Reset in the 4th data bit of 0xFF
    rx_in = 1'b0;
    wait_ticks(16);
    rx_in = 1'b1;
    wait_ticks(16 * 3 + 4);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_active", rx_active, 0);
    chk("midrst_fe", framing_error, 0);
    chk("midrst_pe", parity_error, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(16 * 6);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    chk("post_rst_data", data_out, 8'h5A);
    idle(32);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      r_d     = 8'($urandom);
      r_pt    = 2'($urandom);
      r_st    = 1'($urandom);
      r_dl    = 1'($urandom);
      r_pbit  = par_bit(r_dl ? r_d : (r_d & 8'h7F), r_pt == 2'b01) ^ ($urandom_range(0, 3) == 0);
      r_stops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      send_frame(r_d, r_pt, r_st, r_dl, r_pbit, r_stops, 1'b1);
      idle(2 + int'($urandom_range(0, 40)));
    end

    idle(48);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
